mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Single challenge stage of the mux-arbiter PUF, with a clocked arbiter. A crossover mux routes inputs a/b straight or swapped under challenge bit sel onto a1/b1. A synchronous arbiter then decides which routed signal rose first and reports a registered response bit with a one-cycle valid pulse. The block sits at the end of the PUF delay chain, and its a1/b1 outputs can also feed the next stage.

## Interface

Clocking: one clock; reset is synchronous and active-high.

Parameters:
- TIE_RESP, default 0: response bit reported when a1 and b1 rise in the same sampled cycle.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- a, input, 1: race signal A, synchronous to clk.
- b, input, 1: race signal B, synchronous to clk.
- sel, input, 1: challenge bit. 0 = straight, 1 = crossed.
- a1, output, 1: routed signal, `sel ? b : a`. Combinational.
- b1, output, 1: routed signal, `sel ? a : b`. Combinational.
- resp, output, 1: arbiter decision. 1 = a1 first, 0 = b1 first. Registered and held.
- resp_valid, output, 1: one-cycle pulse when a new resp is captured.
- tie, output, 1: set with resp when both rose in the same cycle. Held with resp.

## Operation

Mux path:
- a1/b1 are pure combinational and independent of clk/rst.
- A change on a, b or sel propagates in the same cycle.

Edge detection:
- a_q and b_q register a1/b1 every cycle.
- rise_a = a1 & ~a_q; rise_b = b1 & ~b_q.

State machine:
- ARMED, then a rise seen:
  - rise_a only: resp←1, tie←0, resp_valid←1, go to DECIDED.
  - rise_b only: resp←0, tie←0, resp_valid←1, go to DECIDED.
  - rise_a and rise_b together: resp←TIE_RESP, tie←1, resp_valid←1, go to DECIDED.
- ARMED, no rise: stay in ARMED.
- DECIDED:
  - Every rise is ignored, and resp and tie hold.
  - When a1=0 and b1=0 are sampled, return to ARMED.
  - Returning to ARMED does not itself fire a decision.
- resp_valid is 1 only on the cycle following a capture. Otherwise it is 0.

Special cases:
- A sel change in ARMED swaps a1/b1. The resulting 0→1 transitions count as rises; this is a legitimate race.
- A sel change in DECIDED has no effect on resp.

Reset (rst=1 at a clk edge):
- state←ARMED; a_q←0, b_q←0; resp←0, tie←0, resp_valid←0.
- Reset has priority over any simultaneous rise.
- An input already high on the first post-reset edge counts as a rise, because a_q/b_q are 0.

## Timing

- a1/b1: zero-cycle latency from a, b, sel.
- Capture: a rise present at edge k is registered at edge k. resp, tie and resp_valid change at edge k.
- resp_valid drops at edge k+1.
- Re-arm: both low sampled at edge m puts the block in ARMED after edge m. A rise sampled at edge m+1 is eligible for capture.
- Minimum spacing between decisions is therefore 2 cycles: one low cycle, then one rise cycle.
- Mid-operation reset: outputs reach reset values at the reset edge, and no resp_valid is emitted on that edge.

## Test plan

- **Mux routing:** drive sel=0, a=1, b=0, which must give a1=1, b1=0. Then set sel=1; in the same cycle a1=0 and b1=1 are required. Walk all 8 combinations of a/b/sel.
- **A wins:** after reset, with sel=0, set a=1 at cycle 5 while b=0. Required: resp=1, tie=0, and resp_valid high for exactly one cycle after the edge at cycle 5. Then raise b=1 at cycle 10; there must be no resp_valid and resp must stay 1.
- **Crossed B wins:** with sel=1, raise a=1. b1 rises, so required are resp=0 and a single resp_valid pulse.
- **Tie and re-arm:**
  - With TIE_RESP=0, raise a and b in the same cycle. Required: resp=0, tie=1, and one pulse.
  - Drop both to 0 for one cycle, then raise b only. A new pulse is required, with resp=0 and tie=0.
- **No re-arm while high:** after a decision, drop a only and keep b=1. Then raise a again; no resp_valid may occur.
- **Reset:**
  - Assert rst in the same cycle as a rise on a. Required: resp=0, resp_valid=0, tie=0.
  - Release reset with a=1 already high. On the first edge, capture is required: resp=1 with one pulse.

Source files
------------

// File: rtl/mux_arbiter.sv
// One challenge stage of a mux-arbiter PUF: a crossover mux routes a/b under sel,
// and a clocked arbiter reports which routed signal rose first.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ARMED   | waiting for the first rise on a1/b1; next rise is captured
// DECIDED | resp/tie held; rises ignored until a1 and b1 both sample low
module mux_arbiter #(
    parameter bit TIE_RESP = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic a1,
    output logic b1,
    output logic resp,
    output logic resp_valid,
    output logic tie
);

    typedef enum logic {
        ARMED   = 1'b0,
        DECIDED = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic a_q;
    logic b_q;
    logic rise_a;
    logic rise_b;
    logic rise_any;
    logic both_low;
    logic capture;
    logic resp_nxt;
    logic tie_nxt;

    // Crossover mux is purely combinational so the chain can continue downstream.
    assign a1 = sel ? b : a;
    assign b1 = sel ? a : b;

    assign rise_a   = a1 & ~a_q;
    assign rise_b   = b1 & ~b_q;
    assign rise_any = rise_a | rise_b;
    assign both_low = ~a1 & ~b1;

    // State register, edge-detect history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARMED;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            resp       <= 1'b0;
            tie        <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_q        <= a1;
            b_q        <= b1;
            resp       <= resp_nxt;
            tie        <= tie_nxt;
            resp_valid <= capture;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARMED: begin
                if (rise_any) begin
                    state_nxt = DECIDED;
                end
            end
            DECIDED: begin
                // Re-arm only on a fully quiet sample, never on a partial drop.
                if (both_low) begin
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_comb begin
        capture  = 1'b0;
        resp_nxt = resp;
        tie_nxt  = tie;
        if (state == ARMED && rise_any) begin
            capture = 1'b1;
            tie_nxt = rise_a & rise_b;
            if (rise_a & rise_b) begin
                resp_nxt = TIE_RESP;
            end else begin
                resp_nxt = rise_a;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: mux truth table, a vector table of clocked
// sequences, and hand-written multi-cycle corner cases.
module tb_mux_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic sel = 1'b0;

    logic a1, b1, resp, resp_valid, tie;
    logic t_a1, t_b1, t_resp, t_resp_valid, t_tie;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.TIE_RESP(1'b0)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
        .a1(a1), .b1(b1), .resp(resp), .resp_valid(resp_valid), .tie(tie)
    );

    mux_arbiter #(.TIE_RESP(1'b1)) dut_t1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
        .a1(t_a1), .b1(t_b1), .resp(t_resp), .resp_valid(t_resp_valid), .tie(t_tie)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        logic  rst, a, b, sel;
        logic  exp_a1, exp_b1, exp_resp, exp_valid, exp_tie;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic r, input logic va, input logic vb,
                                input logic s, input logic ea1, input logic eb1,
                                input logic er, input logic ev, input logic et);
        vec_t v;
        v.name = n; v.rst = r; v.a = va; v.b = vb; v.sel = s;
        v.exp_a1 = ea1; v.exp_b1 = eb1; v.exp_resp = er; v.exp_valid = ev; v.exp_tie = et;
        return v;
    endfunction

    // Drive after negedge, check mux immediately, then registered outputs #1 after posedge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; a = v.a; b = v.b; sel = v.sel;
        #1;
        check({v.name, ".a1"}, a1, v.exp_a1);
        check({v.name, ".b1"}, b1, v.exp_b1);
        @(posedge clk);
        #1;
        check({v.name, ".resp"}, resp, v.exp_resp);
        check({v.name, ".valid"}, resp_valid, v.exp_valid);
        check({v.name, ".tie"}, tie, v.exp_tie);
    endtask

    task automatic step(input logic r, input logic va, input logic vb, input logic s);
        @(negedge clk);
        rst = r; a = va; b = vb; sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;

        // Mux truth table: {a,b,sel} -> {a1,b1}, no clock needed.
        vecs.push_back(mk("mux000", 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mux001", 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mux010", 1, 0, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("mux011", 1, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("mux100", 1, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("mux101", 1, 1, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("mux110", 1, 1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("mux111", 1, 1, 1, 1, 1, 1, 0, 0, 0));
        // Clocked sequences (reset held through the mux walk above).
        vecs.push_back(mk("reset",          1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("a_wins",         0, 1, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("valid_drop",     0, 1, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("late_b_ignored", 0, 1, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("drop_a_only",    0, 0, 1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("no_rearm_high",  0, 1, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("rearm",          0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("tie",            0, 1, 1, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk("tie_hold",       0, 1, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk("rearm2",         0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("b_only",         0, 0, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("rearm3",         0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("crossed_a1",     0, 0, 1, 1, 1, 0, 1, 1, 0));
        vecs.push_back(mk("sel_in_decided", 0, 0, 1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("rearm4",         0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("crossed_b_wins", 0, 1, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk("rearm5",         0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rst_with_rise",  1, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("post_rst_high",  0, 1, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("reset_mid",      1, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("after_reset",    0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // A wins at cycle 5, late B at cycle 10: exactly one pulse, resp stays 1.
        step(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0);
        pulses = 0;
        for (int c = 5; c < 10; c++) begin
            step(0, 1, 0, 0);
            if (resp_valid) pulses++;
        end
        check("seq_a.resp", resp, 1'b1);
        check("seq_a.tie", tie, 1'b0);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL seq_a.pulses: got %0d expected 1", pulses);
        end
        pulses = 0;
        for (int c = 10; c < 15; c++) begin
            step(0, 1, 1, 0);
            if (resp_valid) pulses++;
        end
        check("seq_b_late.resp", resp, 1'b1);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL seq_b_late.pulses: got %0d expected 0", pulses);
        end

        // Tie with TIE_RESP=1 instance, then minimum two-cycle re-decision.
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        check("t1_tie.resp", t_resp, 1'b1);
        check("t1_tie.tie", t_tie, 1'b1);
        check("t1_tie.valid", t_resp_valid, 1'b1);
        check("t0_tie.resp", resp, 1'b0);
        step(0, 0, 0, 0);
        check("t1_rearm.valid", t_resp_valid, 1'b0);
        step(0, 1, 0, 0);
        check("t1_redecide.resp", t_resp, 1'b1);
        check("t1_redecide.tie", t_tie, 1'b0);
        check("t1_redecide.valid", t_resp_valid, 1'b1);
        check("t0_redecide.resp", resp, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
